// File: rtl/key_debounce.sv
// key_debounce
//   Per-bit debouncer and press-event latch for the active-low front-panel
//   buttons. Each raw pin is brought into the clk domain through two flops,
//   and a new level is accepted only after it has been seen for DEBOUNCE
//   consecutive cycles. Accepted edges produce one-cycle press/release
//   pulses, and a sticky press flag that the host clears with clr_i.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   raw_i      raw button pins (asynchronous, 0 = pressed)
//   clr_i      one-cycle clear mask for event_o
//   state_o    debounced level (0 = pressed)
//   press_o    one-cycle pulse on debounced 1->0
//   release_o  one-cycle pulse on debounced 0->1
//   event_o    sticky press flags
//   all_rel_o  1 when no button is pressed
module key_debounce #(
  parameter int WIDTH    = 13,
  parameter int DEBOUNCE = 50000,
  parameter int CNT_W    = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] event_o,
  output logic             all_rel_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [WIDTH-1:0] event_q, event_d;
  logic             all_rel_q, all_rel_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      // Any sample matching the accepted level restarts the stability run.
      if (s2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          state_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_d   = state_q & ~state_d;
    release_d = ~state_q & state_d;
    // A press on the same cycle as a clear keeps the flag set.
    event_d   = press_d | (event_q & ~clr_i);
    all_rel_d = &state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '1;
      s2_q      <= '1;
      state_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      event_q   <= '0;
      all_rel_q <= 1'b1;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
      all_rel_q <= all_rel_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign event_o   = event_q;
  assign all_rel_o = all_rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE=4. A cycle model pushes the
// expected outputs for every edge into a queue; after the edge the entry is
// popped and compared against the DUT, alongside fixed expectations at the
// points of interest in each scenario.
module tb_key_debounce;

  localparam int W   = 13;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_i = '0;
  logic [W-1:0] clr_i = '0;
  logic [W-1:0] state_o, press_o, release_o, event_o;
  logic         all_rel_o;

  key_debounce #(.WIDTH(W), .DEBOUNCE(DEB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .raw_i(raw_i), .clr_i(clr_i),
    .state_o(state_o), .press_o(press_o), .release_o(release_o),
    .event_o(event_o), .all_rel_o(all_rel_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] state, press, rel, evt;
    logic         all_rel;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_s1, m_s2, m_state, m_press, m_rel, m_evt;
  logic         m_all;
  int           m_cnt [W];
  int           press2_cnt = 0;
  logic [W-1:0] press_acc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] ns;
    exp_t e;
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_state = '1;
      m_press = '0; m_rel = '0; m_evt = '0; m_all = 1'b1;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else begin
      ns = m_state;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_state[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DEB - 1) begin
          ns[i] = m_s2[i];
          m_cnt[i] = 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end
      m_press = m_state & ~ns;
      m_rel   = ~m_state & ns;
      m_evt   = m_press | (m_evt & ~clr_i);
      m_all   = &ns;
      m_state = ns;
      m_s2    = m_s1;
      m_s1    = raw_i;
    end
    e.state = m_state; e.press = m_press; e.rel = m_rel;
    e.evt = m_evt; e.all_rel = m_all;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_state",   state_o,   e.state);
    check("sb_press",   press_o,   e.press);
    check("sb_release", release_o, e.rel);
    check("sb_event",   event_o,   e.evt);
    check("sb_all_rel", all_rel_o, e.all_rel);
    if (press_o[2]) press2_cnt++;
    press_acc = press_acc | press_o;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // 1: reset with all pins low, then let every bit fall together
    ticks(2);
    check("rst_state",   state_o,   13'h1FFF);
    check("rst_event",   event_o,   13'h0000);
    check("rst_all_rel", all_rel_o, 1'b1);
    check("rst_press",   press_o,   13'h0000);
    check("rst_release", release_o, 13'h0000);
    reset = 1'b0;
    ticks(5);
    check("t1_state_hold", state_o, 13'h1FFF);
    tick();
    check("t1_state_fall", state_o,   13'h0000);
    check("t1_press_all",  press_o,   13'h1FFF);
    check("t1_event_all",  event_o,   13'h1FFF);
    check("t1_all_rel",    all_rel_o, 1'b0);
    tick();
    check("t1_press_end",  press_o,   13'h0000);
    raw_i = '1;
    ticks(8);
    clr_i = '1;
    tick();
    clr_i = '0;
    check("t1_cleared", event_o, 13'h0000);
    check("t1_idle",    state_o, 13'h1FFF);

    // 2: clean press and release of bit 4
    raw_i[4] = 1'b0;
    ticks(5);
    check("t2_hold", state_o, 13'h1FFF);
    tick();
    check("t2_state",   state_o,   13'h1FEF);
    check("t2_press",   press_o,   13'h0010);
    check("t2_event",   event_o,   13'h0010);
    check("t2_all_rel", all_rel_o, 1'b0);
    tick();
    check("t2_press_end", press_o, 13'h0000);
    ticks(4);
    raw_i[4] = 1'b1;
    ticks(5);
    check("t2_rel_hold", state_o, 13'h1FEF);
    tick();
    check("t2_rel_state", state_o,   13'h1FFF);
    check("t2_release",   release_o, 13'h0010);
    check("t2_rel_all",   all_rel_o, 1'b1);
    tick();

    // 3: bounce on bit 2 is rejected, then a long hold is accepted once
    press_acc = '0;
    raw_i[2] = 1'b0; ticks(3);
    raw_i[2] = 1'b1; ticks(1);
    raw_i[2] = 1'b0; ticks(3);
    raw_i[2] = 1'b1; ticks(6);
    check("t3_bounce_state", state_o,      13'h1FFF);
    check("t3_bounce_press", press_acc[2], 1'b0);
    check("t3_bounce_event", event_o,      13'h0010);
    press2_cnt = 0;
    raw_i[2] = 1'b0; ticks(10);
    check("t3_one_press", press2_cnt, 1);
    check("t3_event",     event_o,    13'h0014);
    raw_i[2] = 1'b1; ticks(8);

    // 4: clear on the press edge loses, clear one cycle later wins
    raw_i[7] = 1'b0;
    ticks(5);
    clr_i[7] = 1'b1;
    tick();
    check("t4_press", press_o,  13'h0080);
    check("t4_set_wins", event_o, 13'h0094);
    tick();
    clr_i = '0;
    check("t4_cleared", event_o, 13'h0014);
    raw_i[7] = 1'b1; ticks(8);

    // 5: reset in the middle of a count discards it
    raw_i[0] = 1'b0;
    ticks(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_state", state_o, 13'h1FFF);
    check("t5_rst_event", event_o, 13'h0000);
    ticks(5);
    check("t5_not_early", state_o, 13'h1FFF);
    tick();
    check("t5_state", state_o, 13'h1FFE);
    check("t5_press", press_o, 13'h0001);
    raw_i[0] = 1'b1; ticks(8);

    // 6: two bits pressed on the same edge
    raw_i[12:11] = 2'b00;
    ticks(5);
    check("t6_hold", press_o, 13'h0000);
    tick();
    check("t6_press",   press_o,   13'h1800);
    check("t6_state",   state_o,   13'h07FF);
    check("t6_all_rel", all_rel_o, 1'b0);
    tick();
    check("t6_press_end", press_o, 13'h0000);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
